program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the instruction-memory interface that fetch reads from.
- Accepts a byte stream with a valid/ready handshake and packs it into 32-bit words in opcode lane order.
- Writes each word to consecutive word addresses of instruction memory.
- Holds the CPU (cpu_clock and the whole datapath) in reset until the program is fully loaded.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  program byte.
- byte_last  input  1  qualifies byte_data as the final program byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- load_start  input  1  one-cycle pulse; restarts loading from DONE or ERROR.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  word to write.
- cpu_reset  output  1  reset to the CPU; high while loading.
- load_done  output  1  program loaded successfully (sticky).
- load_error  output  1  program exceeded memory depth (sticky).
- words_written  output  ADDR_WIDTH+1  count of words written since the last start.

Behaviour:
- Reset is asynchronous and active-high. While reset is high, the state is IDLE and the outputs are:
  - mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_reset=1, load_done=0, load_error=0, words_written=0
  - internal byte index=0, assembly register=0
- Reset asserted mid-operation discards any partial word. No write is issued.
- States:
  - IDLE: no bytes yet in the current word.
  - COLLECT: 1–3 bytes held.
  - WRITE: word pending.
  - DONE.
  - ERROR.
- byte_ready is 1 in IDLE and COLLECT and 0 in WRITE, DONE and ERROR. It is decoded combinationally from state.
- A handshake occurs when byte_valid && byte_ready at a rising edge.
- Byte lane order: byte 0 of a word goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0]. This matches how decode reads the opcode from the upper byte of ope.
- A word completes on the handshake of its 4th byte, or on any handshake with byte_last=1. The next state is WRITE.
- Unfilled lanes of a short final word are 0.
- Write timing: if the completing handshake is at edge N, then mem_we=1 during the cycle after edge N and for exactly one cycle.
  - mem_addr holds the current word address and mem_wdata holds the assembled word.
  - Both stay stable while mem_we=1. They hold their last value afterwards.
- On the edge that ends WRITE:
  - words_written increments and the word address increments.
  - The byte index clears.
  - Next state is DONE if byte_last was seen. Otherwise it is ERROR if the word just written was at address 2**ADDR_WIDTH-1. Otherwise it is IDLE.
  - A program that exactly fills memory, with byte_last on its final byte, goes to DONE, not ERROR.
- Word address arithmetic is ADDR_WIDTH bits. It never wraps, because ERROR is entered first.
- Entering DONE sets load_done=1. cpu_reset falls one cycle after the final mem_we cycle, i.e. registered on entry to DONE.
- Entering ERROR sets load_error=1. cpu_reset stays 1 and no further writes occur.
- byte_valid is ignored in WRITE, DONE and ERROR.
- load_start in DONE or ERROR moves to IDLE on the next edge and does all of the following:
  - sets cpu_reset=1
  - clears load_done, load_error, words_written and the word address
  - leaves mem_addr and mem_wdata unchanged until the next write
- load_start in IDLE, COLLECT or WRITE is ignored.
- load_start coincident with reset: reset wins.
- byte_last on a byte that is also the 4th of a word produces a single full-word write, then DONE.

Test Plan:
- Reset then bytes 8b,5d,fc,55 (last on 55) -> one mem_we pulse, addr 0, wdata 32'h8b5dfc55; the cycle after, load_done=1, cpu_reset=0, words_written=1.
- 6 bytes 01..06, last on 06 -> writes addr0=32'h01020304, addr1=32'h05060000; byte_ready low exactly in the write cycles; then DONE.
- Bytes presented with byte_valid toggling 1/0 each cycle -> same words as a back-to-back stream; no write before the 4th handshake.
- ADDR_WIDTH=2 and 17 bytes without last -> 4 writes (addr 0..3), then load_error=1, cpu_reset=1, byte_ready=0, 5th word never written. Repeat with 16 bytes and last on byte 16 -> DONE, load_error=0.
- Assert reset after 2 bytes of a word -> no mem_we; all outputs at reset values; a new stream restarts at addr 0.
- From DONE, pulse load_start, load 4 bytes aa,bb,cc,dd with last -> cpu_reset high during the reload; write at addr 0 with 32'haabbccdd; load_done reasserts.

Source files
------------

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory write port of the loader.
// master is the byte source / memory side, slave is the loader.
interface program_loader_if #(parameter int ADDR_WIDTH = 8);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_last;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    modport master (output byte_valid, byte_data, byte_last, input byte_ready, mem_we, mem_addr, mem_wdata);
    modport slave (input byte_valid, byte_data, byte_last, output byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/program_loader.sv
// program_loader: packs a byte stream into 32-bit words (first byte in [31:24]), writes them to
// consecutive instruction-memory addresses and holds the CPU in reset until the load completes.
module program_loader #(parameter int ADDR_WIDTH = 8) (
    input  logic                clk,
    input  logic                reset,
    program_loader_if.slave     bus,
    input  logic                load_start,
    output logic                cpu_reset,
    output logic                load_done,
    output logic                load_error,
    output logic [ADDR_WIDTH:0] words_written
);
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;
    state_t state, next_state;
    logic [1:0] byte_idx;
    logic [31:0] asm_word, word_next;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic last_seen, hs, word_end, restart;
    assign bus.byte_ready = (state == IDLE) || (state == COLLECT);
    assign bus.mem_we = state == WRITE;
    assign hs = bus.byte_valid && bus.byte_ready;
    assign word_end = hs && ((byte_idx == 2'd3) || bus.byte_last);
    assign restart = ((state == DONE) || (state == ERROR)) && load_start;
    assign word_next = asm_word | ({bus.byte_data, 24'd0} >> {byte_idx, 3'b000});
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE, COLLECT: if (hs) next_state = word_end ? WRITE : COLLECT;
            WRITE:         next_state = last_seen ? DONE : (&word_addr ? ERROR : IDLE);
            DONE, ERROR:   if (load_start) next_state = IDLE;
            default:       next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx      <= '0;
            asm_word      <= '0;
            word_addr     <= '0;
            last_seen     <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            words_written <= '0;
            cpu_reset     <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            if (hs) begin
                asm_word <= word_next;
                byte_idx <= byte_idx + 2'd1;
            end
            if (word_end) begin
                bus.mem_addr  <= word_addr;
                bus.mem_wdata <= word_next;
                last_seen     <= bus.byte_last;
            end
            // the word just written frees the assembly register for the next word
            if (state == WRITE) begin
                words_written <= words_written + 1'b1;
                word_addr     <= word_addr + 1'b1;
                byte_idx      <= '0;
                asm_word      <= '0;
                if (next_state == DONE) begin
                    load_done <= 1'b1;
                    cpu_reset <= 1'b0;
                end
                if (next_state == ERROR) load_error <= 1'b1;
            end
            if (restart) begin
                cpu_reset     <= 1'b1;
                load_done     <= 1'b0;
                load_error    <= 1'b0;
                words_written <= '0;
                word_addr     <= '0;
            end
        end
    end
endmodule
